// File: rtl/psum_collector.sv
// Per-column psum FIFOs that realign skewed mac_row outputs into one row, read via valid/ready.
// Optional read-path ReLU on the output bus when PSUM_COLLECTOR_RELU_EN is defined.
module psum_collector #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in_s,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
`ifdef PSUM_COLLECTOR_RELU_EN
  input  logic                   relu_en,
`endif
  output logic [psum_bw*col-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   overflow
);

  localparam int unsigned AW = $clog2(depth);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(depth);

  logic [psum_bw-1:0] mem_q  [col][depth];
  logic [AW-1:0]      wptr_q [col];
  logic [AW-1:0]      wptr_d [col];
  logic [AW-1:0]      rptr_q [col];
  logic [AW-1:0]      rptr_d [col];
  logic [AW:0]        cnt_q  [col];
  logic [AW:0]        cnt_d  [col];
  logic               overflow_q;
  logic               overflow_d;

  logic [col-1:0]     empty;
  logic [col-1:0]     full;
  logic [col-1:0]     wen;
  logic               pop;

  always_comb begin
    empty = '0;
    full  = '0;
    for (int unsigned i = 0; i < col; i++) begin
      empty[i] = (cnt_q[i] == '0);
      full[i]  = (cnt_q[i] == DEPTH_CNT);
    end
  end

  assign o_valid  = ~|empty;
  assign o_full   = |full;
  assign o_ready  = ~|full;
  assign overflow = overflow_q;
  assign pop      = rd & o_valid;

  // A full column still accepts a write when the same cycle pops the row.
  always_comb begin
    wen        = '0;
    overflow_d = overflow_q;
    for (int unsigned i = 0; i < col; i++) begin
      wen[i]    = wr[i] & (~full[i] | pop);
      wptr_d[i] = wptr_q[i] + AW'(wen[i]);
      rptr_d[i] = rptr_q[i] + AW'(pop);
      cnt_d[i]  = cnt_q[i];
      case ({wen[i], pop})
        2'b10:   cnt_d[i] = cnt_q[i] + 1'b1;
        2'b01:   cnt_d[i] = cnt_q[i] - 1'b1;
        default: cnt_d[i] = cnt_q[i];
      endcase
      if (wr[i] && full[i] && !pop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q     <= '{default: '0};
      rptr_q     <= '{default: '0};
      cnt_q      <= '{default: '0};
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately not reset; the occupancy counters gate its visibility.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < col; i++) begin
      if (wen[i]) mem_q[i][wptr_q[i]] <= in_s[i*psum_bw +: psum_bw];
    end
  end

  always_comb begin
    out = '0;
    for (int unsigned i = 0; i < col; i++) begin
      logic [psum_bw-1:0] head;
      head = mem_q[i][rptr_q[i]];
`ifdef PSUM_COLLECTOR_RELU_EN
      if (relu_en && head[psum_bw-1]) head = '0;
`endif
      out[i*psum_bw +: psum_bw] = o_valid ? head : '0;
    end
  end

endmodule

// File: tb/tb_psum_collector.sv
// Scoreboard bench for psum_collector: expected rows are queued on write and checked on pop.
module tb_psum_collector;

  localparam int COL   = 8;
  localparam int BW    = 16;
  localparam int DEPTH = 16;
  localparam int W     = COL*BW;

  logic           clk = 1'b0;
  logic           reset;
  logic [W-1:0]   in_s;
  logic [COL-1:0] wr;
  logic           rd;
  logic [W-1:0]   out;
  logic           o_valid, o_full, o_ready, overflow;
`ifdef PSUM_COLLECTOR_RELU_EN
  logic           relu_en;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q [$];

  psum_collector #(.col(COL), .psum_bw(BW), .depth(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_s     (in_s),
    .wr       (wr),
    .rd       (rd),
`ifdef PSUM_COLLECTOR_RELU_EN
    .relu_en  (relu_en),
`endif
    .out      (out),
    .o_valid  (o_valid),
    .o_full   (o_full),
    .o_ready  (o_ready),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] mk_row(input logic [BW-1:0] base);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < COL; i++) r[i*BW +: BW] = base + BW'(i);
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_row();
    logic [W-1:0] r;
    for (int i = 0; i < W/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic push_row(input logic [W-1:0] row);
    in_s = row;
    wr   = '1;
    exp_q.push_back(row);
    cyc();
    wr   = '0;
  endtask

  task automatic pop_row(input string tag);
    logic [W-1:0] e;
    check_eq({tag, "_valid"}, W'(o_valid), W'(1));
    if (exp_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, W'(1), W'(0));
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, out, e);
    end
    rd = 1'b1;
    cyc();
    rd = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    exp_q.delete();
    cyc();
  endtask

  initial begin
    logic [W-1:0] row;
    reset = 1'b0;
    in_s  = rnd_row();
    wr    = '1;
    rd    = 1'b0;
`ifdef PSUM_COLLECTOR_RELU_EN
    relu_en = 1'b0;
`endif

    // Reset held with writes requested
    #1;
    for (int c = 0; c < 3; c++) begin
      cyc();
      check_eq("rst_ready", W'(o_ready), W'(1));
      check_eq("rst_valid", W'(o_valid), W'(0));
      check_eq("rst_ovf",   W'(overflow), W'(0));
      check_eq("rst_out",   out, '0);
    end
    reset = 1'b1;
    wr    = '0;
    cyc();
    check_eq("idle_valid", W'(o_valid), W'(0));
    check_eq("idle_full",  W'(o_full),  W'(0));

    // Read on empty is ignored
    rd = 1'b1;
    cyc();
    rd = 1'b0;
    row = mk_row(16'h0100);
    push_row(row);
    check_eq("rd_empty_valid", W'(o_valid), W'(1));
    pop_row("rd_empty_row");
    check_eq("rd_empty_drained", W'(o_valid), W'(0));

    // Skewed fill, one column per cycle
    row = mk_row(16'h0010);
    for (int i = 0; i < COL; i++) begin
      in_s = rnd_row();
      in_s[i*BW +: BW] = row[i*BW +: BW];
      wr = COL'(1) << i;
      cyc();
      wr = '0;
      check_eq($sformatf("skew_valid%0d", i), W'(o_valid), W'(i == COL-1));
    end
    exp_q.push_back(row);
    pop_row("skew_row");
    check_eq("skew_cleared", W'(o_valid), W'(0));

    // Fill to full, then a dropped write
    for (int k = 0; k < DEPTH; k++) push_row(mk_row(BW'(k*16)));
    check_eq("full_full",  W'(o_full),   W'(1));
    check_eq("full_ready", W'(o_ready),  W'(0));
    check_eq("full_ovf0",  W'(overflow), W'(0));
    in_s = {COL{16'hDEAD}};
    wr   = '1;
    cyc();
    wr   = '0;
    check_eq("drop_ovf",  W'(overflow), W'(1));
    check_eq("drop_head", out, mk_row(16'h0000));
    for (int k = 0; k < DEPTH; k++) pop_row($sformatf("drain%0d", k));
    check_eq("drain_valid", W'(o_valid),  W'(0));
    check_eq("ovf_sticky",  W'(overflow), W'(1));
    do_reset();
    check_eq("ovf_cleared", W'(overflow), W'(0));

    // Full with simultaneous read and write
    for (int k = 0; k < DEPTH; k++) push_row(mk_row(BW'(16'h0200 + k*16)));
    check_eq("simul_pre_full", W'(o_full), W'(1));
    check_eq("simul_head", out, exp_q.pop_front());
    row  = {COL{16'h0AAA}};
    in_s = row;
    wr   = '1;
    rd   = 1'b1;
    exp_q.push_back(row);
    cyc();
    wr   = '0;
    rd   = 1'b0;
    check_eq("simul_ovf",  W'(overflow), W'(0));
    check_eq("simul_full", W'(o_full),   W'(1));
    for (int k = 0; k < DEPTH-1; k++) pop_row($sformatf("simul_drain%0d", k));
    check_eq("simul_last", out, row);
    pop_row("simul_last_pop");
    check_eq("simul_empty", W'(o_valid), W'(0));

    // Streaming across pointer wraps
    push_row(rnd_row());
    for (int k = 1; k < 40; k++) begin
      row = rnd_row();
      check_eq($sformatf("wrap_valid%0d", k), W'(o_valid), W'(1));
      check_eq($sformatf("wrap%0d", k), out, exp_q.pop_front());
      in_s = row;
      wr   = '1;
      rd   = 1'b1;
      exp_q.push_back(row);
      cyc();
    end
    wr = '0;
    rd = 1'b0;
    pop_row("wrap_last");
    check_eq("wrap_empty", W'(o_valid), W'(0));
    check_eq("wrap_ovf",   W'(overflow), W'(0));

    // Asynchronous reset mid-operation
    for (int k = 0; k < 3; k++) push_row(rnd_row());
    in_s = rnd_row();
    wr   = COL'(1);
    cyc();
    wr   = '0;
    #2 reset = 1'b0;
    #1;
    check_eq("async_valid", W'(o_valid), W'(0));
    check_eq("async_out",   out, '0);
    cyc();
    reset = 1'b1;
    exp_q.delete();
    cyc();
    check_eq("post_rst_valid", W'(o_valid), W'(0));
    check_eq("post_rst_ready", W'(o_ready), W'(1));

`ifdef PSUM_COLLECTOR_RELU_EN
    row = mk_row(16'h0040);
    row[3*BW +: BW] = 16'hFFF0;
    row[4*BW +: BW] = 16'h0005;
    push_row(row);
    relu_en = 1'b1;
    #1;
    check_eq("relu_s3", W'(out[3*BW +: BW]), W'(0));
    check_eq("relu_s4", W'(out[4*BW +: BW]), W'(16'h0005));
    relu_en = 1'b0;
    #1;
    check_eq("norelu_s3", W'(out[3*BW +: BW]), W'(16'hFFF0));
    pop_row("relu_row");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
